hex_display_driver: RTL and testbench

- Parametrised multi-digit hex seven-segment driver for SONAR debug/status displays; generalises the single-digit combinational hex decoder.
- Latches a packed hex value on a load strobe and drives registered per-digit segment outputs in parallel.
- Also drives a time-multiplexed scanned port (one digit at a time) for boards with shared segment lines.
- Adds leading-zero suppression, per-digit blanking, blink and selectable output polarity.

---
 rtl/hex_display_driver.sv | 149 ++++++++++++++
 tb/tb_hex_display_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_driver.sv
// Multi-digit hex seven-segment driver: latched value, registered parallel segments,
// a time-multiplexed scan port, leading-zero suppression, blanking, blink and polarity.
module hex_display_driver #(
    parameter int NUM_DIGITS = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    input  logic                    blink_en,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic [6:0]              scan_seg,
    output logic [NUM_DIGITS-1:0]   scan_sel
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0]         DARK       = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] value_reg;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;
    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        scan_idx;

    logic [7*NUM_DIGITS-1:0] seg_next;
    logic [6:0]              scan_seg_next;
    logic [NUM_DIGITS-1:0]   scan_sel_next;
    logic [IDX_W-1:0]        idx_next;
    logic                    blink_dark;
    logic                    blink_wrap;
    logic                    scan_wrap;

    // Font is stored active-low; the other polarity is a plain inversion.
    function automatic logic [6:0] hex_font(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return ACTIVE_LOW ? seg : ~seg;
    endfunction

    // Gating the phase with blink_en lets digits relight on the same edge blink is dropped.
    assign blink_dark = blink_en && blink_phase;
    assign blink_wrap = (blink_cnt == BLINK_LAST);
    assign scan_wrap  = (scan_cnt == SCAN_LAST);

    always_comb begin
        idx_next = scan_idx;
        if (scan_wrap) begin
            idx_next = (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
        end
    end

    // Walk digits from the most significant down, tracking "everything above is zero".
    always_comb begin
        logic       upper_zero;
        logic       lz_dark;
        logic [3:0] digit;
        int unsigned pos;
        seg_next   = '0;
        upper_zero = 1'b1;
        lz_dark    = 1'b0;
        digit      = '0;
        pos        = 0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            pos        = NUM_DIGITS - 1 - k;
            digit      = value_reg[4*pos +: 4];
            upper_zero = upper_zero && (digit == 4'h0);
            lz_dark    = lz_suppress && upper_zero && (pos != 0);
            if (blank_mask[pos] || blink_dark || lz_dark) begin
                seg_next[7*pos +: 7] = DARK;
            end else begin
                seg_next[7*pos +: 7] = hex_font(digit);
            end
        end
    end

    // The scan port picks from the same next-state slice as seg_out so both stay coherent.
    always_comb begin
        scan_seg_next = DARK;
        scan_sel_next = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == idx_next) begin
                scan_seg_next    = seg_next[7*k +: 7];
                scan_sel_next[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            scan_cnt    <= '0;
            scan_idx    <= '0;
            seg_out     <= {NUM_DIGITS{DARK}};
            scan_seg    <= DARK;
            scan_sel    <= NUM_DIGITS'(1);
        end else begin
            if (load) begin
                value_reg <= value;
            end

            if (!blink_en) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
            scan_idx <= idx_next;
            seg_out  <= seg_next;
            scan_seg <= scan_seg_next;
            scan_sel <= scan_sel_next;
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: three parameterisations, directed table vectors,
// hand-written blink/scan/reset sequences and randomized traffic against a reference model.
module tb_hex_display_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // dut0: 4 digits, active-low, blink 4, scan 3
    logic        load0 = 1'b0, lz0 = 1'b0, blink0 = 1'b0;
    logic [15:0] value0 = '0;
    logic [3:0]  mask0 = '0;
    logic [27:0] seg0;
    logic [6:0]  sseg0;
    logic [3:0]  ssel0;
    // dut1: 2 digits, active-high, blink 3, scan 2
    logic        load1 = 1'b0, lz1 = 1'b0, blink1 = 1'b0;
    logic [7:0]  value1 = '0;
    logic [1:0]  mask1 = '0;
    logic [13:0] seg1;
    logic [6:0]  sseg1;
    logic [1:0]  ssel1;
    // dut2: 1 digit, active-low, blink 1, scan 1
    logic        load2 = 1'b0, lz2 = 1'b0, blink2 = 1'b0;
    logic [3:0]  value2 = '0;
    logic [0:0]  mask2 = '0;
    logic [6:0]  seg2;
    logic [6:0]  sseg2;
    logic [0:0]  ssel2;

    hex_display_driver #(.NUM_DIGITS(4), .ACTIVE_LOW(1'b1), .BLINK_DIV(4), .SCAN_DIV(3)) dut0 (
        .clk(clk), .reset(reset), .load(load0), .value(value0), .blank_mask(mask0),
        .lz_suppress(lz0), .blink_en(blink0), .seg_out(seg0), .scan_seg(sseg0), .scan_sel(ssel0));
    hex_display_driver #(.NUM_DIGITS(2), .ACTIVE_LOW(1'b0), .BLINK_DIV(3), .SCAN_DIV(2)) dut1 (
        .clk(clk), .reset(reset), .load(load1), .value(value1), .blank_mask(mask1),
        .lz_suppress(lz1), .blink_en(blink1), .seg_out(seg1), .scan_seg(sseg1), .scan_sel(ssel1));
    hex_display_driver #(.NUM_DIGITS(1), .ACTIVE_LOW(1'b1), .BLINK_DIV(1), .SCAN_DIV(1)) dut2 (
        .clk(clk), .reset(reset), .load(load2), .value(value2), .blank_mask(mask2),
        .lz_suppress(lz2), .blink_en(blink2), .seg_out(seg2), .scan_seg(sseg2), .scan_sel(ssel2));

    int n_pass = 0;
    int n_total = 0;

    // Reference model: active-low font, digit count, polarity, blink and scan divisors per DUT
    logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    int ND_T [3] = '{4, 2, 1};
    bit AL_T [3] = '{1'b1, 1'b0, 1'b1};
    int BD_T [3] = '{4, 3, 1};
    int SD_T [3] = '{3, 2, 1};

    logic [31:0] m_v  [3];
    int          m_bk [3];
    int          m_e  [3];
    logic [55:0] x_seg  [3];
    logic [6:0]  x_sseg [3];
    logic [7:0]  x_sel  [3];

    function automatic logic [55:0] model_seg(int nd, bit al, logic [31:0] v, logic [7:0] mask,
                                              bit lz, bit dark_all);
        logic [55:0] r = '0;
        logic [6:0]  s;
        for (int i = 0; i < nd; i++) begin
            if (dark_all || mask[i] || (lz && i != 0 && (v >> (4*i)) == 0)) s = 7'b1111111;
            else s = font[v[4*i +: 4]];
            if (!al) s = ~s;
            r[7*i +: 7] = s;
        end
        return r;
    endfunction

    task automatic model_edge(input int d, input bit ld, input logic [31:0] val,
                              input logic [7:0] msk, input bit lzs, input bit blk);
        bit phase;
        int idx;
        phase = !reset && blk && ((m_bk[d] / BD_T[d]) % 2 == 1);
        x_seg[d] = model_seg(ND_T[d], AL_T[d], m_v[d], msk, lzs, reset || phase);
        if (reset) begin
            m_v[d] = 0; m_bk[d] = 0; m_e[d] = 0;
        end else begin
            if (ld) m_v[d] = val;
            m_bk[d] = blk ? m_bk[d] + 1 : 0;
            m_e[d]  = m_e[d] + 1;
        end
        idx = (m_e[d] / SD_T[d]) % ND_T[d];
        x_sel[d]  = 8'(1) << idx;
        x_sseg[d] = x_seg[d][7*idx +: 7];
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic step();
        model_edge(0, load0, 32'(value0), 8'(mask0), lz0, blink0);
        model_edge(1, load1, 32'(value1), 8'(mask1), lz1, blink1);
        model_edge(2, load2, 32'(value2), 8'(mask2), lz2, blink2);
        @(posedge clk);
        #1;
        check("seg0",  seg0,  x_seg[0][27:0]);
        check("sseg0", sseg0, x_sseg[0]);
        check("ssel0", ssel0, x_sel[0][3:0]);
        check("seg1",  seg1,  x_seg[1][13:0]);
        check("sseg1", sseg1, x_sseg[1]);
        check("ssel1", ssel1, x_sel[1][1:0]);
        check("seg2",  seg2,  x_seg[2][6:0]);
        check("sseg2", sseg2, x_sseg[2]);
        check("ssel2", ssel2, x_sel[2][0:0]);
    endtask

    typedef struct {
        logic [15:0] v;
        logic        lz;
        logic [3:0]  mask;
        logic [27:0] exp;
    } vec_t;
    vec_t tbl [7];

    localparam logic [6:0] DK = 7'b1111111;
    localparam logic [27:0] ZEROS = {4{7'b1000000}};
    localparam logic [27:0] ABCD = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
    logic [6:0] scan_exp [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_v[d] = '0; m_bk[d] = 0; m_e[d] = 0;
        end
        tbl[0] = '{16'h1234, 1'b0, 4'b0000, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        tbl[1] = '{16'h0050, 1'b1, 4'b0000, {DK, DK, 7'b0010010, 7'b1000000}};
        tbl[2] = '{16'h0000, 1'b1, 4'b0000, {DK, DK, DK, 7'b1000000}};
        tbl[3] = '{16'h0000, 1'b1, 4'b0001, {DK, DK, DK, DK}};
        tbl[4] = '{16'hABCD, 1'b0, 4'b0000, ABCD};
        tbl[5] = '{16'h8E6F, 1'b0, 4'b0100, {7'b0000000, DK, 7'b0000010, 7'b0001110}};
        tbl[6] = '{16'h0907, 1'b1, 4'b0000, {DK, 7'b0011000, 7'b1000000, 7'b1111000}};

        // reset state
        step(); step();
        check("rst_seg", seg0, {4{DK}});
        check("rst_sseg", sseg0, DK);
        check("rst_sel", ssel0, 4'b0001);
        reset = 1'b0;
        step();
        check("post_rst", seg0, ZEROS);

        // static decode vectors: load edge, then one edge for the outputs
        for (int i = 0; i < 7; i++) begin
            load0 = 1'b1; value0 = tbl[i].v; lz0 = tbl[i].lz; mask0 = tbl[i].mask;
            step();
            load0 = 1'b0;
            step();
            check($sformatf("tbl%0d", i), seg0, tbl[i].exp);
        end
        lz0 = 1'b0; mask0 = '0;

        // blink: 4 lit, then dark; dropping blink_en mid-dark relights on the next edge
        load0 = 1'b1; value0 = 16'hABCD;
        step();
        load0 = 1'b0; blink0 = 1'b1;
        for (int k = 0; k < 4; k++) begin step(); check("blink_lit", seg0, ABCD); end
        for (int k = 0; k < 2; k++) begin step(); check("blink_dark", seg0, {4{DK}}); end
        blink0 = 1'b0;
        step();
        check("blink_off", seg0, ABCD);

        // reset with load of FFFF in the middle of a dark blink phase
        blink0 = 1'b1;
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1; load0 = 1'b1; value0 = 16'hFFFF;
        step();
        check("rstld_seg", seg0, {4{DK}});
        check("rstld_sel", ssel0, 4'b0001);
        reset = 1'b0; blink0 = 1'b0; value0 = 16'h000F;
        step();
        check("rstld_vreg", seg0, ZEROS);
        load0 = 1'b0;
        step();
        check("load_f", seg0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b0001110});

        // scan walk from reset with value 1234
        reset = 1'b1;
        step();
        reset = 1'b0; load0 = 1'b1; value0 = 16'h1234;
        step();
        load0 = 1'b0;
        for (int e = 2; e < 14; e++) begin
            step();
            check("scan_sel", ssel0, 4'(4'b0001 << ((e / 3) % 4)));
            check("scan_seg", sseg0, scan_exp[(e / 3) % 4]);
        end

        // inverted polarity, two digits
        load1 = 1'b1; value1 = 8'h80;
        step();
        load1 = 1'b0;
        step();
        check("al0_seg", seg1, {7'b1111111, 7'b0111111});
        mask1 = 2'b10;
        step();
        check("al0_blank", seg1, {7'b0000000, 7'b0111111});
        mask1 = 2'b00;

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            reset  = ($urandom_range(0, 59) == 0);
            load0  = ($urandom_range(0, 2) == 0);
            value0 = 16'($urandom) >> (4 * $urandom_range(0, 3));
            mask0  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            lz0    = 1'($urandom);
            if ($urandom_range(0, 9) == 0) blink0 = ~blink0;
            load1  = ($urandom_range(0, 2) == 0);
            value1 = 8'($urandom) >> (4 * $urandom_range(0, 1));
            mask1  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            lz1    = 1'($urandom);
            if ($urandom_range(0, 9) == 0) blink1 = ~blink1;
            load2  = 1'($urandom);
            value2 = 4'($urandom);
            mask2  = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
            lz2    = 1'($urandom);
            blink2 = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
